// File: rtl/integral_image_gen.sv
// integral_image_gen: takes a row-major pixel stream for one tile and
// computes the tile's summed-area (integral) image. Each result word is
// written to image memory at addr = row*width + col.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   start                begin a frame (accepted only in IDLE)
//   img_width/height     tile size, latched when start is accepted
//   pix_valid/pix_data   input pixel stream
//   pix_ready            high in RUN; a pixel is accepted on valid && ready
//   wr_en/addr/data      image-memory write port, one cycle after accept
//   busy                 high in RUN and FLUSH
//   done                 one-cycle pulse when the frame completes
//   err                  sticky: bad dimensions or SUM_W overflow
module integral_image_gen #(
  parameter int MAX_WIDTH = 320,
  parameter int ADDR_W    = 17,
  parameter int PIX_W     = 8,
  parameter int SUM_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       img_width,
  input  logic [15:0]       img_height,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [SUM_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int XW = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic [15:0]       w_q, h_q, y;
  logic [XW-1:0]     x;
  logic [SUM_W-1:0]  rowsum;
  logic [ADDR_W-1:0] addr;
  // Previous row's integral values, indexed by column; never reset.
  logic [SUM_W-1:0]  linebuf [MAX_WIDTH];

  logic              accept, dims_bad, last_col, last_pix;
  logic [31:0]       area;
  logic [SUM_W-1:0]  above;
  logic [SUM_W:0]    rs_full, ii_full;

  assign pix_ready = (state == RUN);
  assign busy      = (state == RUN) || (state == FLUSH);
  assign accept    = pix_valid && pix_ready;

  assign area     = 32'(img_width) * 32'(img_height);
  assign dims_bad = (img_width == 16'd0) || (img_height == 16'd0) ||
                    (32'(img_width) > 32'(MAX_WIDTH)) ||
                    ({1'b0, area} > (33'd1 << ADDR_W));

  assign last_col = (16'(x) == w_q - 16'd1);
  assign last_pix = last_col && (y == h_q - 16'd1);

  // Row 0 forces zero so stale line-buffer contents from an earlier or
  // aborted frame never leak into the result.
  assign above   = (y == 16'd0) ? '0 : linebuf[x];
  // One extra bit on each add catches carry-out for the overflow flag.
  assign rs_full = {1'b0, rowsum} + (SUM_W+1)'(pix_data);
  assign ii_full = {1'b0, above} + {1'b0, rs_full[SUM_W-1:0]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !dims_bad) state_nxt = RUN;
      RUN:     if (accept && last_pix) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      x       <= '0;
      y       <= '0;
      rowsum  <= '0;
      addr    <= '0;
      w_q     <= '0;
      h_q     <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          w_q <= img_width;
          h_q <= img_height;
          if (dims_bad) err <= 1'b1;
          else begin
            err    <= 1'b0;
            x      <= '0;
            y      <= '0;
            rowsum <= '0;
            addr   <= '0;
          end
        end
        RUN: if (accept) begin
          wr_en   <= 1'b1;
          wr_addr <= addr;
          wr_data <= ii_full[SUM_W-1:0];
          addr    <= addr + ADDR_W'(1);
          if (rs_full[SUM_W] || ii_full[SUM_W]) err <= 1'b1;
          if (last_col) begin
            x      <= '0;
            rowsum <= '0;
            y      <= y + 16'd1;
          end else begin
            x      <= x + XW'(1);
            rowsum <= rs_full[SUM_W-1:0];
          end
        end
        FLUSH: done <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) linebuf[x] <= ii_full[SUM_W-1:0];
  end
endmodule

// File: tb/tb_integral_image_gen.sv
// Directed bench for integral_image_gen. Expected writes come from an
// inclusion-exclusion model of the summed-area table and are queued when
// each pixel is accepted; a negedge monitor pops and compares them.
module tb_integral_image_gen;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [15:0] img_width = '0, img_height = '0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        pix_ready, wr_en, busy, done, err;
  logic [16:0] wr_addr;
  logic [31:0] wr_data;

  integral_image_gen dut (
    .clk(clk), .reset(reset), .start(start),
    .img_width(img_width), .img_height(img_height),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [16:0] a; logic [31:0] d;} exp_t;
  exp_t        sbq[$];
  exp_t        mon_e;
  int          errors = 0, checks = 0, nwr = 0, ndone = 0, cyc = 0, done_cyc = 0;
  logic [16:0] last_a;
  logic [31:0] last_d;
  longint      prv[320], cur[320];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      nwr++;
      last_a = wr_addr;
      last_d = wr_data;
      chk("sb_nonempty", 64'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(mon_e.a));
        chk("wr_data", 64'(wr_data), 64'(mon_e.d));
      end
    end
    if (done === 1'b1) begin
      ndone++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // pval < 0 streams pixel index; stop_after > 0 returns after that many
  // accepts; mid_start >= 0 pulses start with that pixel.
  task automatic run_frame(input int w, input int h, input int pval, input bit gaps,
                           input int stop_after, input int mid_start, output int t_start);
    int idx = 0;
    int t, p;
    longint ii;
    img_width = 16'(w); img_height = 16'(h); start = 1'b1;
    t_start = cyc;
    tick();
    start = 1'b0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        p  = (pval < 0) ? (idx & 255) : pval;
        ii = p;
        if (y > 0) ii += prv[x];
        if (x > 0) ii += cur[x-1];
        if (x > 0 && y > 0) ii -= prv[x-1];
        cur[x] = ii;
        if (gaps && idx > 0) begin pix_valid = 1'b0; tick(); end
        if (idx == mid_start) begin start = 1'b1; img_width = 16'd2; img_height = 16'd2; end
        pix_valid = 1'b1; pix_data = 8'(p);
        t = 0;
        while (!pix_ready && t < 20) begin tick(); t++; end
        if (t == 20) chk("pix_ready_timeout", 64'(pix_ready), 1);
        sbq.push_back({17'(y*w + x), 32'(ii)});
        tick();
        pix_valid = 1'b0; start = 1'b0;
        idx++;
        if (idx == stop_after) return;
      end
      for (int x = 0; x < w; x++) prv[x] = cur[x];
    end
  endtask

  task automatic finish_frame(input string tag, input int n, input int d0, input int w0, input int t_start);
    for (int t = 0; t < 50 && ndone == d0; t++) tick();
    repeat (3) tick();
    chk({tag, "_done_pulses"}, 64'(ndone - d0), 1);
    chk({tag, "_done_time"}, 64'(done_cyc - t_start), 64'(n + 2));
    chk({tag, "_writes"}, 64'(nwr - w0), 64'(n));
    chk({tag, "_sb_empty"}, 64'(sbq.size()), 0);
    chk({tag, "_err"}, 64'(err), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
  endtask

  task automatic bad_start(input string tag, input int w, input int h);
    int w0 = nwr;
    img_width = 16'(w); img_height = 16'(h); start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_err"}, 64'(err), 1);
    repeat (3) tick();
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_ready"}, 64'(pix_ready), 0);
    chk({tag, "_nowr"}, 64'(nwr - w0), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, w0, ts;
    repeat (3) tick();
    chk("rst_ready", 64'(pix_ready), 0);
    chk("rst_wr_en", 64'(wr_en), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_wr_addr", 64'(wr_addr), 0);
    chk("rst_wr_data", 64'(wr_data), 0);
    reset = 1'b0;
    tick();

    // 3x3 of ones, continuous
    d0 = ndone; w0 = nwr;
    run_frame(3, 3, 1, 1'b0, 0, -1, ts);
    finish_frame("f3x3", 9, d0, w0, ts);
    chk("f3x3_last_data", 64'(last_d), 9);

    // 4x2 ramp with a valid gap every other cycle
    d0 = ndone; w0 = nwr;
    run_frame(4, 2, -1, 1'b1, 0, -1, ts);
    for (int t = 0; t < 50 && ndone == d0; t++) tick();
    repeat (3) tick();
    chk("f4x2_writes", 64'(nwr - w0), 8);
    chk("f4x2_last_data", 64'(last_d), 28);
    chk("f4x2_done", 64'(ndone - d0), 1);

    // wide tile of 255s
    d0 = ndone; w0 = nwr;
    run_frame(316, 3, 255, 1'b0, 0, -1, ts);
    finish_frame("f316", 948, d0, w0, ts);
    chk("f316_last_addr", 64'(last_a), 947);
    chk("f316_last_data", 64'(last_d), 241740);

    // dimension errors, then a good start clears err
    bad_start("w0", 0, 4);
    bad_start("w321", 321, 2);
    bad_start("area", 320, 410);
    d0 = ndone; w0 = nwr;
    run_frame(2, 1, 5, 1'b0, 0, -1, ts);
    finish_frame("f2x1", 2, d0, w0, ts);
    chk("f2x1_last_data", 64'(last_d), 10);

    // start together with reset is ignored
    reset = 1'b1; start = 1'b1; img_width = 16'd3; img_height = 16'd3;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    chk("rst_start_busy", 64'(busy), 0);

    // abort an 8x8 frame after 20 pixels
    d0 = ndone; w0 = nwr;
    run_frame(8, 8, 200, 1'b0, 20, -1, ts);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("abort_wr_en", 64'(wr_en), 0);
    chk("abort_busy", 64'(busy), 0);
    repeat (10) tick();
    chk("abort_writes", 64'(nwr - w0), 20);
    chk("abort_no_done", 64'(ndone - d0), 0);
    chk("abort_sb_empty", 64'(sbq.size()), 0);
    sbq.delete();

    // restart: row 0 must ignore stale line buffer
    d0 = ndone; w0 = nwr;
    run_frame(2, 2, 1, 1'b0, 0, -1, ts);
    finish_frame("f2x2", 4, d0, w0, ts);
    chk("f2x2_last_data", 64'(last_d), 4);

    // start pulsed mid-frame is ignored
    d0 = ndone; w0 = nwr;
    run_frame(3, 3, 1, 1'b0, 0, 4, ts);
    finish_frame("midstart", 9, d0, w0, ts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
